// File: rtl/pipe_pkg.sv
// Shared types for the pipeline register stage: control bundle layout,
// its bit indices, and the skid-buffer occupancy states.
package pipe_pkg;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branchs;
    logic jumps;
  } ctrl_t;

  localparam int CTRL_BITS       = $bits(ctrl_t);
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_MEM_READ   = 4;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 2;
  localparam int CTRL_BRANCHS    = 1;
  localparam int CTRL_JUMPS      = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Payload is {IR, nIR, PC, B, Result, RegDest, Zero}.
  function automatic int payload_w(input int data_w, input int dest_w);
    return 5 * data_w + dest_w + 1;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with registered in_ready; only used when the
// stage is built with PIPE_SKID_EN.
//
//   state | meaning
//   EMPTY | nothing held, out_valid=0
//   ONE   | head entry valid, skid entry free
//   FULL  | head and skid both valid, in_ready=0
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 6,
  parameter int PAY_W  = 166
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [PAY_W-1:0]  in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [PAY_W-1:0]  out_data
);

  skid_state_e       state;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [CTRL_W-1:0] head_ctrl;
  logic [PAY_W-1:0]  head_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [PAY_W-1:0]  skid_data;
  logic              accept;
  logic              handoff;

  assign accept  = in_valid && in_ready_q && !flush;
  assign handoff = out_valid_q && out_ready;

  // head_ctrl is zeroed whenever the stage goes empty so out_ctrl is a bubble.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_ctrl   <= '0;
      head_data   <= '0;
      skid_ctrl   <= '0;
      skid_data   <= '0;
    end else if (flush) begin
      state       <= EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_ctrl   <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state       <= ONE;
            out_valid_q <= 1'b1;
            head_ctrl   <= in_ctrl;
            head_data   <= in_data;
          end
        end
        ONE: begin
          if (accept && handoff) begin
            head_ctrl <= in_ctrl;
            head_data <= in_data;
          end else if (accept) begin
            state      <= FULL;
            in_ready_q <= 1'b0;
            skid_ctrl  <= in_ctrl;
            skid_data  <= in_data;
          end else if (handoff) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            head_ctrl   <= '0;
          end
        end
        FULL: begin
          if (handoff) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
            head_ctrl  <= skid_ctrl;
            head_data  <= skid_data;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          head_ctrl   <= '0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_ctrl  = head_ctrl;
  assign out_data  = head_data;

endmodule

// File: rtl/pipe_stage_skid.sv
// EX/MEM-style pipeline register stage with valid/ready handshake and flush.
// Define PIPE_SKID_EN for the two-entry skid buffer; default is one entry.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 6,
  parameter int DEST_W = 5
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [5*DATA_W+DEST_W:0]   in_data,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [5*DATA_W+DEST_W:0]   out_data
);

  localparam int PAY_W = payload_w(DATA_W, DEST_W);

`ifdef PIPE_SKID_EN

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .PAY_W  (PAY_W)
  ) u_skid (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

`else

  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [PAY_W-1:0]  data_q;
  logic              accept;
  logic              handoff;

  // A held beat leaving this cycle frees the slot for the incoming one.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;
  assign handoff  = valid_q && out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      ctrl_q  <= in_ctrl;
      data_q  <= in_data;
    end else if (handoff) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;

`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus a random
// phase, all compared every cycle against a bounded-queue reference model.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 6;
  localparam int DEST_W = 5;
  localparam int PAY_W  = 5 * DATA_W + DEST_W + 1;
  localparam int RES_LSB = DEST_W + 1;
  localparam int PC_LSB  = DEST_W + 1 + 2 * DATA_W;
`ifdef PIPE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic              clock;
  logic              reset_n;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [PAY_W-1:0]  in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PAY_W-1:0]  out_data;

  pipe_stage_skid #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .DEST_W (DEST_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic [PAY_W-1:0]  data;
  } beat_t;

  beat_t            mq[$];
  logic [PAY_W-1:0] m_last = '0;
  logic             m_acc;
  logic             m_hof;
  int               n_pass;
  int               n_total;

  // Stage as a FIFO of capacity CAP; in_ready follows the build's rule.
  function automatic logic exp_ready(input int occ, input logic ordy);
    if (CAP == 2) return occ < 2;
    return (occ == 0) || ordy;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_last = '0;
    end else begin
      m_acc = in_valid && exp_ready(mq.size(), out_ready) && !flush;
      m_hof = (mq.size() > 0) && out_ready;
      if (flush) mq.delete();
      else begin
        if (m_hof) void'(mq.pop_front());
        if (m_acc) mq.push_back('{in_ctrl, in_data});
      end
      if (mq.size() > 0) m_last = mq[0].data;
    end
  end

  task automatic check(input string name, input logic [PAY_W-1:0] act,
                       input logic [PAY_W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic compare_loop();
    logic             ev;
    logic [PAY_W-1:0] ed;
    logic [CTRL_W-1:0] ec;
    forever begin
      @(negedge clock);
      ev = mq.size() > 0;
      ec = ev ? mq[0].ctrl : '0;
      ed = ev ? mq[0].data : m_last;
      check("model_out_valid", PAY_W'(out_valid), PAY_W'(ev));
      check("model_out_ctrl", PAY_W'(out_ctrl), PAY_W'(ec));
      check("model_out_data", out_data, ed);
      check("model_in_ready", PAY_W'(in_ready), PAY_W'(exp_ready(mq.size(), out_ready)));
    end
  endtask

  function automatic logic [PAY_W-1:0] mk(input logic [31:0] pc, input logic [31:0] res);
    return {32'($urandom), 32'($urandom), pc, 32'($urandom), res, 5'($urandom), 1'($urandom)};
  endfunction

  function automatic logic [31:0] pc_of(input logic [PAY_W-1:0] d);
    return d[PC_LSB +: DATA_W];
  endfunction

  function automatic logic [31:0] res_of(input logic [PAY_W-1:0] d);
    return d[RES_LSB +: DATA_W];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [31:0] seq;
    n_pass   = 0;
    n_total  = 0;
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_ctrl  = 6'b111111;
    in_data  = mk(32'hdead_beef, 32'hcafe_f00d);
    flush    = 1'b0;
    out_ready = 1'b0;
    fork
      compare_loop();
    join_none

    // Reset held with a beat offered
    repeat (3) step();
    check("rst_out_valid", PAY_W'(out_valid), '0);
    check("rst_out_ctrl", PAY_W'(out_ctrl), '0);
    check("rst_out_data", out_data, '0);
    in_valid = 1'b0;
    @(negedge clock);
    #2 reset_n = 1'b1;
    #1 check("rst_in_ready", PAY_W'(in_ready), PAY_W'(1'b1));

    // Single beat
    step();
    in_valid  = 1'b1;
    in_ctrl   = 6'b100000;
    in_data   = mk(32'h0000_0040, 32'h1234_5678);
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("single_valid", PAY_W'(out_valid), PAY_W'(1'b1));
    check("single_pc", PAY_W'(pc_of(out_data)), PAY_W'(32'h0000_0040));
    check("single_result", PAY_W'(res_of(out_data)), PAY_W'(32'h1234_5678));
    check("single_ctrl", PAY_W'(out_ctrl), PAY_W'(6'b100000));
    check("single_regwrite", PAY_W'(out_ctrl[CTRL_REG_WRITE]), PAY_W'(1'b1));
    step();
    check("single_gone", PAY_W'(out_valid), '0);
    check("single_bubble_ctrl", PAY_W'(out_ctrl), '0);

    // Backpressure: A then B with out_ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 6'b010100;
    in_data   = mk(32'h0000_0100, 32'h1);
    step();
    in_ctrl   = 6'b101000;
    in_data   = mk(32'h0000_0104, 32'h2);
    step();
`ifdef PIPE_SKID_EN
    in_valid = 1'b0;
`endif
    check("bp_in_ready", PAY_W'(in_ready), '0);
    check("bp_head_a", PAY_W'(pc_of(out_data)), PAY_W'(32'h0000_0100));
    repeat (2) begin
      step();
      check("bp_stable_pc", PAY_W'(pc_of(out_data)), PAY_W'(32'h0000_0100));
      check("bp_stable_ctrl", PAY_W'(out_ctrl), PAY_W'(6'b010100));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("bp_then_b_valid", PAY_W'(out_valid), PAY_W'(1'b1));
    check("bp_then_b_pc", PAY_W'(pc_of(out_data)), PAY_W'(32'h0000_0104));
    step();
    check("bp_drained", PAY_W'(out_valid), '0);

    // Flush while full, with a beat offered in the same cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 6'b111000;
    in_data   = mk(32'h0000_0200, 32'h3);
    step();
    for (int i = 1; i < CAP; i++) begin
      in_data = mk(32'h0000_0200 + 32'(4 * i), 32'h4);
      step();
    end
    check("fl_full_ready", PAY_W'(in_ready), '0);
    flush   = 1'b1;
    in_ctrl = 6'b111111;
    in_data = mk(32'h0000_02fc, 32'h5);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_valid", PAY_W'(out_valid), '0);
    check("fl_ctrl", PAY_W'(out_ctrl), '0);
    check("fl_in_ready", PAY_W'(in_ready), PAY_W'(1'b1));
    check("fl_data_kept", PAY_W'(pc_of(out_data)), PAY_W'(32'h0000_0200));
    out_ready = 1'b1;
    repeat (3) begin
      step();
      check("fl_no_ghost", PAY_W'(out_valid), '0);
    end

    // Streaming: one beat per cycle with no stall
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_ctrl = 6'($urandom);
      in_data = mk(32'(4 * i), 32'($urandom));
      step();
      check("st_valid", PAY_W'(out_valid), PAY_W'(1'b1));
      check("st_pc", PAY_W'(pc_of(out_data)), PAY_W'(32'(4 * i)));
      check("st_in_ready", PAY_W'(in_ready), PAY_W'(1'b1));
    end
    in_valid = 1'b0;
    step();
    check("st_drained", PAY_W'(out_valid), '0);

    // Async reset while full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 6'b100100;
    for (int i = 0; i < CAP; i++) begin
      in_data = mk(32'h0000_0300 + 32'(4 * i), 32'h6);
      step();
    end
    in_valid = 1'b0;
    @(negedge clock);
    check("mr_pre_valid", PAY_W'(out_valid), PAY_W'(1'b1));
    #2 reset_n = 1'b0;
    #1;
    check("mr_valid", PAY_W'(out_valid), '0);
    check("mr_ctrl", PAY_W'(out_ctrl), '0);
    check("mr_data", out_data, '0);
    @(negedge clock);
    #2 reset_n = 1'b1;

    // Random traffic
    seq = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      step();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      in_ctrl   = 6'($urandom);
      in_data   = mk(seq, 32'($urandom));
      seq       = seq + 32'd4;
    end
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
REQ-001 SHALL take parameter DATA_W, default 32, width of each of the five 32-bit payload words (IR, nIR, PC, B, Result).
REQ-002 SHALL take parameter CTRL_W, default 6, control-bundle width; bit order: RegWrite, MemRead, MemWrite, MemToReg, Branchs, Jumps.
REQ-003 SHALL take parameter DEST_W, default 5, width of the register-destination field.
REQ-004 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, upstream beat present.
REQ-007 SHALL have port in_ready, output, 1, stage accepts a beat this cycle.
REQ-008 SHALL have port in_ctrl, input, CTRL_W, upstream control bundle.
REQ-009 SHALL have port in_data, input, 5*DATA_W+DEST_W+1, packed {IR, nIR, PC, B, Result, RegDest, Zero}.
REQ-010 SHALL have port flush, input, 1, synchronous kill of all held beats.
REQ-011 SHALL have port out_valid, output, 1, downstream beat present.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_ctrl, output, CTRL_W, control bundle of the head beat.
REQ-014 SHALL have port out_data, output, 5*DATA_W+DEST_W+1, payload of the head beat.

Function
REQ-015 SHALL accept a beat on a rising edge when in_valid=1 and in_ready=1 and flush=0.
REQ-016 SHALL hand off a beat on a rising edge when out_valid=1 and out_ready=1.
REQ-017 SHALL present an accepted beat on out_* exactly 1 cycle after acceptance when the stage was empty.
REQ-018 SHALL preserve beat order; no beat is duplicated or lost except by flush.
REQ-019 SHALL hold out_ctrl and out_data stable while out_valid=1 and out_ready=0.
REQ-020 SHALL force out_ctrl to all-zero whenever out_valid=0 (bubble: no write enables reach MEM/WB).
REQ-021 SHALL, on flush=1, empty the stage at the next edge: out_valid=0, out_ctrl=0; a simultaneously offered beat is discarded.
REQ-022 SHALL give flush priority over simultaneous accept and hand-off.
REQ-023 SHALL, on simultaneous accept and hand-off with one beat held, replace the head beat with the new one and keep occupancy at one.
REQ-024 SHALL leave out_data unchanged, not cleared, on flush.

Reset
REQ-025 SHALL, while reset_n=0, drive out_valid=0, out_ctrl=0, out_data=0, and empty all storage, with no clock edge required.
REQ-026 SHALL drive in_ready=1 in the first cycle after reset_n deasserts.
REQ-027 SHALL discard any beat in flight when reset asserts mid-transfer.

Configuration
REQ-028 SHALL use the macro PIPE_SKID_EN to select the buffering mode.
REQ-029 SHALL, with PIPE_SKID_EN defined, use a two-entry skid buffer with FSM states EMPTY, ONE, FULL and a registered in_ready=(state!=FULL).
- EMPTY->ONE on accept.
- ONE->FULL on accept without hand-off.
- ONE->EMPTY on hand-off without accept.
- FULL->ONE on hand-off; the skid entry moves to the head.
- Any state->EMPTY on flush.
REQ-030 SHALL, without PIPE_SKID_EN, use a single entry with combinational in_ready=!out_valid||out_ready; no skid storage is synthesised.

Structure
REQ-031 SHALL place the control-bundle typedef, bit-index constants, and the state enum EMPTY/ONE/FULL in shared package pipe_pkg.
REQ-032 SHALL implement the skid storage and FSM in sub-module pipe_skid_buf, instantiated only under PIPE_SKID_EN.

Verification
REQ-033 SHALL cover reset behaviour: hold reset_n=0 with in_valid=1 and in_ctrl=6'b111111 -> out_valid=0, out_ctrl=0, out_data=0; in_ready=1 on the first cycle after release.
REQ-034 SHALL cover a single beat: accept PC=32'h0000_0040, Result=32'h1234_5678, ctrl=6'b100000 at edge N with out_ready=1 -> out_valid=1 with the same values at edge N+1, out_valid=0 at edge N+2.
REQ-035 SHALL cover backpressure in the skid build: hold out_ready=0 while driving beats A then B -> in_ready=0 after 2 accepts; out shows A, stable; release out_ready -> A then B, in order.
REQ-036 SHALL cover flush: with FULL occupancy, pulse flush=1 together with in_valid=1 -> next cycle out_valid=0, out_ctrl=6'b000000, in_ready=1; the flushed and offered beats never appear.
REQ-037 SHALL cover simultaneous accept and hand-off: stream 8 beats with PC=0,4,...,28, in_valid=1 and out_ready=1 -> one beat out per cycle, PCs in order, no stall.
REQ-038 SHALL cover reset mid-stream: assert reset_n=0 asynchronously between edges while FULL -> out_valid falls immediately, before the next edge.
